msu_axis_out_packer: RTL and testbench

//  Downstream of the MSU core: accepts the narrow result stream (t_current, then sq_out words)
//  and packs it into wide beats for the host DMA/AXI-stream port. Word count per transfer is

---
 rtl/msu_axis_out_packer.sv | 133 +++++++++++++
 tb/tb_msu_axis_out_packer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/msu_axis_out_packer.sv
// Packs the narrow MSU result stream into wide AXI-stream beats with tkeep/tlast.
// Optional MSU_OUT_PACK_STATUS_EN adds a completed-transfer counter output.
module msu_axis_out_packer #(
  parameter int IN_LEN            = 32,
  parameter int OUT_LEN           = 512,
  parameter int C_XFER_SIZE_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [IN_LEN-1:0]            s_axis_tdata,
  input  logic [C_XFER_SIZE_WIDTH-1:0] s_axis_xfer_size_in_bytes,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [OUT_LEN-1:0]           m_axis_tdata,
  output logic [OUT_LEN/8-1:0]         m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         busy
`ifdef MSU_OUT_PACK_STATUS_EN
  ,
  output logic [31:0]                  xfer_count
`endif
);

  localparam int R  = OUT_LEN / IN_LEN;
  localparam int WB = IN_LEN / 8;
  localparam int KW = OUT_LEN / 8;
  localparam int SW = $clog2(R + 1);
  localparam int CW = C_XFER_SIZE_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  logic [1:0]         state;
  logic               armed;
  logic [SW-1:0]      slot;
  logic [CW-1:0]      words_left;
  logic [OUT_LEN-1:0] beat;
  logic [KW-1:0]      keep;
  logic               last;

  logic               accept;
  logic [CW-1:0]      words_total;
  logic [SW-1:0]      slot_nx;
  logic [CW-1:0]      left_nx;
  logic               done;
  logic [KW-1:0]      keep_nx;

  assign s_axis_tready = armed && (state != SEND);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = beat;
  assign m_axis_tkeep  = keep;
  assign m_axis_tlast  = last;
  assign busy          = (state != IDLE);

  always_comb begin
    words_total = s_axis_xfer_size_in_bytes / CW'(WB);
    if (words_total == '0) words_total = CW'(1);
    if (state == IDLE) begin
      slot_nx = SW'(1);
      left_nx = words_total - CW'(1);
    end else begin
      slot_nx = slot + SW'(1);
      left_nx = words_left - CW'(1);
    end
    done = (slot_nx == SW'(R)) || (left_nx == '0);
    // Lowest slots are filled first, so keep is a contiguous low mask.
    keep_nx = '0;
    for (int i = 0; i < R; i++) begin
      if (SW'(i) < slot_nx) keep_nx[i*WB +: WB] = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      slot       <= '0;
      words_left <= '0;
      beat       <= '0;
      keep       <= '0;
      last       <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE, FILL: begin
          if (accept) begin
            if (state == IDLE) begin
              beat <= OUT_LEN'(s_axis_tdata);
            end else begin
              for (int i = 0; i < R; i++) begin
                if (SW'(i) == slot) beat[i*IN_LEN +: IN_LEN] <= s_axis_tdata;
              end
            end
            slot       <= slot_nx;
            words_left <= left_nx;
            if (done) begin
              state <= SEND;
              keep  <= keep_nx;
              last  <= (left_nx == '0);
            end else begin
              state <= FILL;
            end
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            beat  <= '0;
            keep  <= '0;
            last  <= 1'b0;
            slot  <= '0;
            state <= last ? IDLE : FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MSU_OUT_PACK_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (state == SEND && m_axis_tready && last) begin
      xfer_count <= xfer_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msu_axis_out_packer.sv
// Directed bench for msu_axis_out_packer at IN_LEN=32, OUT_LEN=128 (four words per beat).
// Define MSU_OUT_PACK_STATUS_EN to also check the transfer counter.
module tb_msu_axis_out_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_tvalid;
  logic         s_tready;
  logic [31:0]  s_tdata;
  logic [31:0]  size;
  logic         m_tvalid;
  logic         m_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tlast;
  logic         busy;
`ifdef MSU_OUT_PACK_STATUS_EN
  logic [31:0]  xfer_count;
`endif

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  beat_t beats[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  msu_axis_out_packer #(
    .IN_LEN(32),
    .OUT_LEN(128),
    .C_XFER_SIZE_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata),
    .s_axis_xfer_size_in_bytes(size),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast),
    .busy(busy)
`ifdef MSU_OUT_PACK_STATUS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  // Handshake completes at the posedge following a negedge where both are high.
  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) beats.push_back('{m_tdata, m_tkeep, m_tlast});
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    int t = 0;
    s_tvalid = 1'b1;
    s_tdata  = w;
    @(negedge clk);
    while (!s_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tdata  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (beats.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("beat_count", 128'(beats.size()), 128'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input int i, input logic [127:0] d,
                            input logic [15:0] k, input logic l);
    if (i < beats.size()) begin
      check({tag, "_data"}, beats[i].data, d);
      check({tag, "_keep"}, 128'(beats[i].keep), 128'(k));
      check({tag, "_last"}, 128'(beats[i].last), 128'(l));
    end else begin
      check({tag, "_missing"}, 0, 1);
    end
  endtask

  initial begin
    logic [127:0] held;
    logic         stable;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    size     = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 128'(m_tvalid), 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tkeep", 128'(m_tkeep), 0);
    check("rst_tlast", 128'(m_tlast), 0);
    check("rst_busy", 128'(busy), 0);
    reset = 1'b0;
    check("rst_sready_lo", 128'(s_tready), 0);
    @(posedge clk);
    #1;
    check("rst_sready_hi", 128'(s_tready), 1);

    // 10 words, size 40 bytes
    size = 32'd40;
    for (int i = 1; i <= 10; i++) push(32'(i));
    wait_beats(3);
    check_beat("t40_b0", 0, {32'h4, 32'h3, 32'h2, 32'h1}, 16'hFFFF, 1'b0);
    check_beat("t40_b1", 1, {32'h8, 32'h7, 32'h6, 32'h5}, 16'hFFFF, 1'b0);
    check_beat("t40_b2", 2, {32'h0, 32'h0, 32'hA, 32'h9}, 16'h00FF, 1'b1);
    check("t40_busy", 128'(busy), 0);
    beats.delete();

    size = 32'd16;
    for (int i = 0; i < 4; i++) push(32'h11 + 32'(i));
    wait_beats(1);
    check_beat("t16", 0, {32'h14, 32'h13, 32'h12, 32'h11}, 16'hFFFF, 1'b1);
    beats.delete();

    size = 32'd0;
    push(32'hAB);
    wait_beats(1);
    check_beat("t0", 0, 128'hAB, 16'h000F, 1'b1);
    beats.delete();

    // Backpressure: first beat held for 20 cycles with word 5 pending
    size     = 32'd32;
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) push(32'h20 + 32'(i));
    s_tvalid = 1'b1;
    s_tdata  = 32'h25;
    @(negedge clk);
    held   = m_tdata;
    stable = m_tvalid;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!m_tvalid || m_tdata !== held || s_tready) stable = 1'b0;
    end
    check("bp_stable", 128'(stable), 1);
    check("bp_held", held, {32'h24, 32'h23, 32'h22, 32'h21});
    m_tready = 1'b1;
    for (int i = 5; i <= 8; i++) push(32'h20 + 32'(i));
    wait_beats(2);
    check_beat("bp_b0", 0, {32'h24, 32'h23, 32'h22, 32'h21}, 16'hFFFF, 1'b0);
    check_beat("bp_b1", 1, {32'h28, 32'h27, 32'h26, 32'h25}, 16'hFFFF, 1'b1);
    beats.delete();

    // Random input gaps, 12 words
    size = 32'd48;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      push(32'h100 + 32'(i));
    end
    wait_beats(3);
    check_beat("gap_b0", 0, {32'h103, 32'h102, 32'h101, 32'h100}, 16'hFFFF, 1'b0);
    check_beat("gap_b1", 1, {32'h107, 32'h106, 32'h105, 32'h104}, 16'hFFFF, 1'b0);
    check_beat("gap_b2", 2, {32'h10B, 32'h10A, 32'h109, 32'h108}, 16'hFFFF, 1'b1);
    beats.delete();

    // Reset after 6 of 10 words
    size = 32'd40;
    for (int i = 1; i <= 6; i++) push(32'h40 + 32'(i));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rmid_busy", 128'(busy), 0);
    check("rmid_nbeats", 128'(beats.size()), 1);
    if (beats.size() > 0) check("rmid_nolast", 128'(beats[0].last), 0);
    beats.delete();
    size = 32'd16;
    for (int i = 0; i < 4; i++) push(32'h50 + 32'(i));
    wait_beats(1);
    check_beat("rmid_next", 0, {32'h53, 32'h52, 32'h51, 32'h50}, 16'hFFFF, 1'b1);
`ifdef MSU_OUT_PACK_STATUS_EN
    check("xfer_count", 128'(xfer_count), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
